ppg_ac_dc_extract: RTL and testbench

Front-end separator that turns raw MAX30102 red/IR samples into the AC/DC pairs and beat pulse consumed by the SpO2 calculator. Each channel gets a running-mean DC estimate over a power-of-two sample window and an AC term equal to raw minus DC, saturated to signed width. A hysteretic IR-AC zero-crossing detector with a refractory counter produces a one-sample beat pulse. The pulse is always coincident with an output-valid cycle, so downstream logic can sample it under its data-valid qualifier.

---
 rtl/ppg_ac_dc_extract_if.sv | 33 +++
 rtl/ppg_ac_dc_extract.sv | 194 +++++++++++++++++++
 tb/tb_ppg_ac_dc_extract.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppg_ac_dc_extract_if.sv
`default_nettype none
// ============================================================================
// Module  : ppg_ac_dc_extract_if
// Brief   : Raw-sample input and AC/DC/beat output bundle for ppg_ac_dc_extract
// Revision: 1.0
// ============================================================================
interface ppg_ac_dc_extract_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  i_sample_valid;
    logic [DATA_WIDTH-1:0] i_red_raw;
    logic [DATA_WIDTH-1:0] i_ir_raw;
    logic                  o_data_valid;
    logic [DATA_WIDTH-1:0] o_red_ac;
    logic [DATA_WIDTH-1:0] o_red_dc;
    logic [DATA_WIDTH-1:0] o_ir_ac;
    logic [DATA_WIDTH-1:0] o_ir_dc;
    logic                  o_beat_pulse;
    logic                  o_dc_ready;

    modport master (
        output i_sample_valid, i_red_raw, i_ir_raw,
        input  o_data_valid, o_red_ac, o_red_dc, o_ir_ac, o_ir_dc,
               o_beat_pulse, o_dc_ready
    );

    modport slave (
        input  i_sample_valid, i_red_raw, i_ir_raw,
        output o_data_valid, o_red_ac, o_red_dc, o_ir_ac, o_ir_dc,
               o_beat_pulse, o_dc_ready
    );
endinterface
`default_nettype wire

// File: rtl/ppg_ac_dc_extract.sv
`default_nettype none
// ============================================================================
// Module  : ppg_ac_dc_extract
// Brief   : Running-mean DC / saturated AC split for red and IR plus IR beat detect
// Revision: 1.0
// ============================================================================
module ppg_ac_dc_extract #(
    parameter int DATA_WIDTH      = 18,
    parameter int AVG_LOG2        = 5,
    parameter int BEAT_THRESH     = 64,
    parameter int REFRACT_SAMPLES = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    ppg_ac_dc_extract_if.slave  ppg_if
);
    localparam int c_DEPTH = 1 << AVG_LOG2;
    localparam int c_SUM_W = DATA_WIDTH + AVG_LOG2;
    localparam int c_REF_W = (REFRACT_SAMPLES > 0) ? $clog2(REFRACT_SAMPLES + 1) : 1;
    localparam logic [AVG_LOG2:0]         c_FILL_FULL   = (AVG_LOG2+1)'(c_DEPTH);
    localparam logic [AVG_LOG2:0]         c_FILL_LAST   = (AVG_LOG2+1)'(c_DEPTH - 1);
    localparam logic signed [DATA_WIDTH-1:0] c_BEAT_THRESH = DATA_WIDTH'(BEAT_THRESH);
    localparam logic [c_REF_W-1:0]        c_REFRACT     = c_REF_W'(REFRACT_SAMPLES);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_ARM     = 2'd1,
        ST_HIGH    = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] w_raw   [2];
    logic [DATA_WIDTH-1:0] w_s2_ac [2];
    logic [DATA_WIDTH-1:0] w_s2_dc [2];

    logic [AVG_LOG2-1:0] r_wp;
    logic [AVG_LOG2:0]   r_fill;
    logic                w_full;
    logic                r_s1_valid;
    logic                r_s2_valid;

    assign w_raw[0] = ppg_if.i_red_raw;
    assign w_raw[1] = ppg_if.i_ir_raw;
    assign w_full   = (r_fill == c_FILL_FULL);

    // Stage 1 control: only samples completing a full window travel down the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_fill     <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= ppg_if.i_sample_valid && (r_fill >= c_FILL_LAST);
            r_s2_valid <= r_s1_valid;
            if (ppg_if.i_sample_valid) begin
                r_wp <= r_wp + 1'b1;
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [DATA_WIDTH-1:0]  r_buf [c_DEPTH];
        logic [c_SUM_W-1:0]     r_sum;
        logic [DATA_WIDTH-1:0]  r_raw_d;
        logic [DATA_WIDTH-1:0]  r_ac;
        logic [DATA_WIDTH-1:0]  r_dc;
        logic [DATA_WIDTH-1:0]  w_oldest;
        logic [DATA_WIDTH-1:0]  w_dc;
        logic signed [DATA_WIDTH:0] w_diff;
        logic [DATA_WIDTH-1:0]  w_ac;

        // Unfilled slots are never read, so the buffer needs no reset
        assign w_oldest = w_full ? r_buf[r_wp] : '0;
        assign w_dc     = DATA_WIDTH'(r_sum >> AVG_LOG2);
        assign w_diff   = $signed({1'b0, r_raw_d}) - $signed({1'b0, w_dc});

        always_comb begin
            w_ac = w_diff[DATA_WIDTH-1:0];
            if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1]) begin
                w_ac = {w_diff[DATA_WIDTH], {(DATA_WIDTH-1){~w_diff[DATA_WIDTH]}}};
            end
        end

        always_ff @(posedge clk) begin
            if (ppg_if.i_sample_valid) begin
                r_buf[r_wp] <= w_raw[ch];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum   <= '0;
                r_raw_d <= '0;
                r_ac    <= '0;
                r_dc    <= '0;
            end else begin
                if (ppg_if.i_sample_valid) begin
                    r_sum   <= r_sum + c_SUM_W'(w_raw[ch]) - c_SUM_W'(w_oldest);
                    r_raw_d <= w_raw[ch];
                end
                if (r_s1_valid) begin
                    r_ac <= w_ac;
                    r_dc <= w_dc;
                end
            end
        end

        assign w_s2_ac[ch] = r_ac;
        assign w_s2_dc[ch] = r_dc;
    end

    state_t               r_state, w_state_nxt;
    logic [c_REF_W-1:0]   r_refract, w_refract_nxt;
    logic                 w_beat;
    logic signed [DATA_WIDTH-1:0] w_ir_ac;

    assign w_ir_ac = $signed(w_s2_ac[1]);

    // One transition per output sample, so the arming sample can never fire
    always_comb begin
        w_state_nxt   = r_state;
        w_refract_nxt = r_refract;
        w_beat        = 1'b0;
        if (r_s2_valid) begin
            case (r_state)
                ST_FILL: w_state_nxt = ST_ARM;
                ST_ARM: begin
                    if (w_ir_ac >= c_BEAT_THRESH) begin
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_ir_ac[DATA_WIDTH-1]) begin
                        w_state_nxt   = ST_REFRACT;
                        w_refract_nxt = c_REFRACT;
                        w_beat        = 1'b1;
                    end
                end
                ST_REFRACT: begin
                    if (r_refract == '0) begin
                        w_state_nxt = ST_ARM;
                    end else begin
                        w_refract_nxt = r_refract - 1'b1;
                    end
                end
                default: w_state_nxt = ST_FILL;
            endcase
        end
    end

    logic                  r_data_valid;
    logic                  r_beat;
    logic                  r_dc_ready;
    logic [DATA_WIDTH-1:0] r_red_ac, r_red_dc, r_ir_ac, r_ir_dc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_refract    <= '0;
            r_data_valid <= 1'b0;
            r_beat       <= 1'b0;
            r_dc_ready   <= 1'b0;
            r_red_ac     <= '0;
            r_red_dc     <= '0;
            r_ir_ac      <= '0;
            r_ir_dc      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_refract    <= w_refract_nxt;
            r_data_valid <= r_s2_valid;
            r_beat       <= w_beat;
            if (r_s2_valid) begin
                r_dc_ready <= 1'b1;
                r_red_ac   <= w_s2_ac[0];
                r_red_dc   <= w_s2_dc[0];
                r_ir_ac    <= w_s2_ac[1];
                r_ir_dc    <= w_s2_dc[1];
            end
        end
    end

    assign ppg_if.o_data_valid = r_data_valid;
    assign ppg_if.o_beat_pulse = r_beat;
    assign ppg_if.o_dc_ready   = r_dc_ready;
    assign ppg_if.o_red_ac     = r_red_ac;
    assign ppg_if.o_red_dc     = r_red_dc;
    assign ppg_if.o_ir_ac      = r_ir_ac;
    assign ppg_if.o_ir_dc      = r_ir_dc;
endmodule
`default_nettype wire

// File: tb/tb_ppg_ac_dc_extract.sv
`default_nettype none
// ============================================================================
// Module  : tb_ppg_ac_dc_extract
// Brief   : Directed self-checking bench; two instances differ only in refractory length
// Revision: 1.0
// ============================================================================
module tb_ppg_ac_dc_extract;
    localparam int W = 18;

    logic         clk;
    logic         rst_n;
    logic         sv;
    logic [W-1:0] red;
    logic [W-1:0] ir;
    int           checks;
    int           errors;

    ppg_ac_dc_extract_if #(.DATA_WIDTH(W)) bus4 ();
    ppg_ac_dc_extract_if #(.DATA_WIDTH(W)) bus20 ();

    assign bus4.i_sample_valid  = sv;
    assign bus4.i_red_raw       = red;
    assign bus4.i_ir_raw        = ir;
    assign bus20.i_sample_valid = sv;
    assign bus20.i_red_raw      = red;
    assign bus20.i_ir_raw       = ir;

    ppg_ac_dc_extract #(
        .DATA_WIDTH(W), .AVG_LOG2(5), .BEAT_THRESH(64), .REFRACT_SAMPLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ppg_if(bus4)
    );

    ppg_ac_dc_extract #(
        .DATA_WIDTH(W), .AVG_LOG2(5), .BEAT_THRESH(64), .REFRACT_SAMPLES(20)
    ) dut20 (
        .clk(clk), .rst_n(rst_n), .ppg_if(bus20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        sv    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents one sample, then waits until its result (if any) is visible
    task automatic send(input logic [W-1:0] r, input logic [W-1:0] i);
        @(negedge clk);
        sv  = 1'b1;
        red = r;
        ir  = i;
        @(negedge clk);
        sv = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus4.o_data_valid !== 1'b0 || bus4.o_dc_ready !== 1'b0 || bus4.o_beat_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: got dv=%b ready=%b beat=%b expected 0/0/0",
                         c, bus4.o_data_valid, bus4.o_dc_ready, bus4.o_beat_pulse);
            end
        end
        checks++;
        if ({bus4.o_red_ac, bus4.o_red_dc, bus4.o_ir_ac, bus4.o_ir_dc} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     bus4.o_red_ac, bus4.o_red_dc, bus4.o_ir_ac, bus4.o_ir_dc);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 31; k++) begin
            send(18'd1000, 18'd2000);
            checks++;
            if (bus4.o_data_valid !== 1'b0 || bus4.o_dc_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_quiet sample %0d: got dv=%b ready=%b expected 0/0",
                         k, bus4.o_data_valid, bus4.o_dc_ready);
            end
        end
        send(18'd1000, 18'd2000);
        checks++;
        if (bus4.o_data_valid !== 1'b1 || bus4.o_dc_ready !== 1'b1 || bus4.o_beat_pulse !== 1'b0) begin
            errors++;
            $display("FAIL fill_first: got dv=%b ready=%b beat=%b expected 1/1/0",
                     bus4.o_data_valid, bus4.o_dc_ready, bus4.o_beat_pulse);
        end
        checks++;
        if (bus4.o_red_dc !== 18'd1000 || bus4.o_ir_dc !== 18'd2000) begin
            errors++;
            $display("FAIL fill_dc: got red=%0d ir=%0d expected 1000/2000", bus4.o_red_dc, bus4.o_ir_dc);
        end
        checks++;
        if (bus4.o_red_ac !== 18'd0 || bus4.o_ir_ac !== 18'd0) begin
            errors++;
            $display("FAIL fill_ac: got red=%0d ir=%0d expected 0/0",
                     $signed(bus4.o_red_ac), $signed(bus4.o_ir_ac));
        end
        @(negedge clk);
        checks++;
        if (bus4.o_data_valid !== 1'b0 || bus4.o_beat_pulse !== 1'b0 || bus4.o_red_dc !== 18'd1000
            || bus4.o_dc_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold: got dv=%b beat=%b red_dc=%0d ready=%b expected 0/0/1000/1",
                     bus4.o_data_valid, bus4.o_beat_pulse, bus4.o_red_dc, bus4.o_dc_ready);
        end
    endtask

    task automatic test_step();
        send(18'd1032, 18'd2000);
        checks++;
        if (bus4.o_data_valid !== 1'b1 || bus4.o_red_dc !== 18'd1001 || bus4.o_red_ac !== 18'd31) begin
            errors++;
            $display("FAIL step: got dv=%b red_dc=%0d red_ac=%0d expected 1/1001/31",
                     bus4.o_data_valid, bus4.o_red_dc, $signed(bus4.o_red_ac));
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 32; k++) send(18'd200000, 18'd2000);
        checks++;
        if (bus4.o_red_dc !== 18'd200000 || bus4.o_red_ac !== 18'd0) begin
            errors++;
            $display("FAIL sat_fill: got red_dc=%0d red_ac=%0d expected 200000/0",
                     bus4.o_red_dc, $signed(bus4.o_red_ac));
        end
        send(18'd0, 18'd2000);
        checks++;
        if (bus4.o_red_dc !== 18'd193750 || bus4.o_red_ac !== 18'h20000) begin
            errors++;
            $display("FAIL sat_neg: got red_dc=%0d red_ac=%0d expected 193750/-131072",
                     bus4.o_red_dc, $signed(bus4.o_red_ac));
        end
    endtask

    task automatic test_beats();
        logic [W-1:0] wave;
        logic         exp4;
        logic         exp20;
        apply_reset();
        for (int k = 0; k < 32; k++) send(18'd1000, 18'd2000);
        for (int k = 0; k < 64; k++) begin
            wave  = ((k % 16) < 8) ? 18'd2200 : 18'd1800;
            exp4  = ((k % 16) == 8);
            exp20 = ((k % 32) == 8);
            send(18'd1000, wave);
            checks++;
            if (bus4.o_data_valid !== 1'b1 || bus4.o_beat_pulse !== exp4) begin
                errors++;
                $display("FAIL beat_r4 sample %0d: got dv=%b beat=%b expected 1/%b",
                         k, bus4.o_data_valid, bus4.o_beat_pulse, exp4);
            end
            checks++;
            if (bus20.o_data_valid !== 1'b1 || bus20.o_beat_pulse !== exp20) begin
                errors++;
                $display("FAIL beat_r20 sample %0d: got dv=%b beat=%b expected 1/%b",
                         k, bus20.o_data_valid, bus20.o_beat_pulse, exp20);
            end
            if (k == 0) begin
                checks++;
                if (bus4.o_ir_ac !== 18'd194 || bus4.o_ir_dc !== 18'd2006) begin
                    errors++;
                    $display("FAIL wave_rise: got ir_ac=%0d ir_dc=%0d expected 194/2006",
                             $signed(bus4.o_ir_ac), bus4.o_ir_dc);
                end
            end
            if (k == 8) begin
                checks++;
                if (bus4.o_ir_ac !== 18'(-243) || bus4.o_ir_dc !== 18'd2043) begin
                    errors++;
                    $display("FAIL wave_fall: got ir_ac=%0d ir_dc=%0d expected -243/2043",
                             $signed(bus4.o_ir_ac), bus4.o_ir_dc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_dv;
        apply_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            exp_dv = ((c >= 34) && (c <= 50)) || (c >= 85);
            checks++;
            if (bus4.o_data_valid !== exp_dv) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d: got %b expected %b", c, bus4.o_data_valid, exp_dv);
            end
            if (c == 51 || c == 85) begin
                checks++;
                if (bus4.o_dc_ready !== exp_dv) begin
                    errors++;
                    $display("FAIL b2b_ready cycle %0d: got %b expected %b", c, bus4.o_dc_ready, exp_dv);
                end
            end
            if (c == 85) begin
                checks++;
                if (bus4.o_red_dc !== 18'd1000 || bus4.o_ir_dc !== 18'd2000) begin
                    errors++;
                    $display("FAIL b2b_dc: got red=%0d ir=%0d expected 1000/2000",
                             bus4.o_red_dc, bus4.o_ir_dc);
                end
            end
            rst_n = (c != 50);
            sv    = 1'b1;
            red   = 18'd1000;
            ir    = 18'd2000;
        end
        @(negedge clk);
        sv = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        sv     = 1'b0;
        red    = '0;
        ir     = '0;
        test_reset();
        test_fill();
        test_step();
        test_saturation();
        test_beats();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
